lut_neuron_array: RTL

- Parametrised, runtime-programmable successor to the fixed per-neuron truth-table ROMs in the LogicNets layers.
- Holds N_NEURONS independent truth tables, each IN_BITS wide in and OUT_BITS wide out, loadable via a configuration port.
- Evaluates all neurons in parallel on a valid/ready stream with a registered output.
- Sits between layer stages of a generated network; one instance replaces one layer of fixed ROM neurons.

---
 rtl/lut_neuron_array.sv | 93 +++++++++
 1 files changed

// File: rtl/lut_neuron_array.sv
// lut_neuron_array: an array of runtime-programmable truth-table neurons.
// Each neuron maps an IN_BITS input to an OUT_BITS result through its own
// table. After reset a sweep zeroes every table before the array runs.
// All neurons are evaluated in parallel on a valid/ready stream, and the
// output is registered.
module lut_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 2,
  parameter int NIDX_W    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [NIDX_W-1:0]             cfg_neuron,
  input  logic [IN_BITS-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data
);

  localparam int DEPTH = 1 << IN_BITS;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]                    state;
  logic [IN_BITS-1:0]            clr_cnt;
  logic [OUT_BITS-1:0]           tbl [N_NEURONS][DEPTH];
  logic [N_NEURONS*OUT_BITS-1:0] lookup;
  logic                          accept;

  assign busy = (state == ST_CLEAR);

  // A config write blocks acceptance, so a beat never reads an entry
  // in the same cycle that the entry is being written.
  assign in_ready = (state == ST_RUN) && !cfg_we && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Clear sweep sequencing: step through every entry once, then run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) begin
        state <= ST_RUN;
      end
    end
  end

  // Single table write port. During the sweep it zeroes one entry in every
  // neuron. Otherwise it performs a config write. An out-of-range neuron
  // index matches no neuron, so nothing is written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_NEURONS; i++) begin
      if (state == ST_CLEAR) begin
        tbl[i][clr_cnt] <= '0;
      end else if (cfg_we && (cfg_neuron == NIDX_W'(i))) begin
        tbl[i][cfg_addr] <= cfg_data;
      end
    end
  end

  // Asynchronous read ports, one per neuron, each indexed by its input slice.
  always_comb begin
    lookup = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      lookup[i*OUT_BITS +: OUT_BITS] = tbl[i][in_data[i*IN_BITS +: IN_BITS]];
    end
  end

  // Output register: load on acceptance, hold under backpressure,
  // and drain when the result is consumed with nothing new arriving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lookup;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
